iq_avg_snapshot_ctrl: RTL

Capture sequencer for the IQ-average snapshot buffer. It arms on a software control-register edge and waits for an optional trigger. It then writes a fixed-depth block of averaged IQ words into the snapshot BRAM and reports progress as a 32-bit status word. That status word drives user_data_in of the snapshot status register (simulink2ppc), and ctrl_in comes from the matching ppc2simulink control register.

---
 rtl/iq_avg_snapshot_ctrl_pkg.sv | 25 ++
 rtl/iq_avg_snapshot_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/iq_avg_snapshot_ctrl_pkg.sv
// Shared definitions for the IQ-average snapshot capture controller.
// Firmware decodes the status word with the same bit positions.
package iq_avg_snapshot_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Control register bit positions
  localparam int unsigned CTRL_ARM       = 0;
  localparam int unsigned CTRL_TRIG_MODE = 1;

  // Status word bit positions
  localparam int unsigned STAT_DONE        = 31;
  localparam int unsigned STAT_CAPTURING   = 30;
  localparam int unsigned STAT_ARMED       = 29;
  localparam int unsigned STAT_TRIG_MODE   = 28;
  localparam int unsigned STAT_ARM_CNT_MSB = 27;
  localparam int unsigned STAT_ARM_CNT_LSB = 20;
  localparam int unsigned STAT_COUNT_MSB   = 16;

endpackage

// File: rtl/iq_avg_snapshot_ctrl.sv
// Capture sequencer: arms on a rising edge of ctrl_in[0], optionally waits
// for trig_in, then writes 2**ADDR_W averaged IQ words into the snapshot BRAM.
module iq_avg_snapshot_ctrl
  import iq_avg_snapshot_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl_in,
  input  logic              trig_in,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic [31:0]       status_out
);

  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   count, count_nxt;
  logic [7:0]        arm_cnt, arm_cnt_nxt;
  logic              trig_mode, trig_mode_nxt;
  logic              arm_prev;
  logic              arm_edge;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic [31:0]       status_nxt;
  logic              ctrl_unused;

  assign ctrl_unused = ^ctrl_in[31:2];
  assign arm_edge    = ctrl_in[CTRL_ARM] & ~arm_prev;

  // Arm edge history; resets high so a level already set at release is ignored
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) arm_prev <= 1'b1;
    else             arm_prev <= ctrl_in[CTRL_ARM];
  end

  // FSM state register
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state, counter and BRAM write decode; an arm edge overrides any write
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    arm_cnt_nxt   = arm_cnt;
    trig_mode_nxt = trig_mode;
    we_nxt        = 1'b0;
    addr_nxt      = bram_addr;
    din_nxt       = bram_din;
    if (arm_edge) begin
      count_nxt     = '0;
      arm_cnt_nxt   = arm_cnt + 8'd1;
      trig_mode_nxt = ctrl_in[CTRL_TRIG_MODE];
      state_nxt     = ctrl_in[CTRL_TRIG_MODE] ? ST_ARMED : ST_CAPTURE;
    end else begin
      case (state)
        ST_ARMED: begin
          // Trigger cycle sample lands at address 0 (count is 0 here)
          if (trig_in) begin
            state_nxt = ST_CAPTURE;
            if (data_valid) begin
              we_nxt    = 1'b1;
              addr_nxt  = '0;
              din_nxt   = data_in;
              count_nxt = count + 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (data_valid) begin
            we_nxt    = 1'b1;
            addr_nxt  = count[ADDR_W-1:0];
            din_nxt   = data_in;
            count_nxt = count + 1'b1;
            if (count == LAST_IDX) state_nxt = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Status word packed from the current (pre-update) registers
  always_comb begin
    status_nxt                                     = '0;
    status_nxt[STAT_DONE]                          = (state == ST_DONE);
    status_nxt[STAT_CAPTURING]                     = (state == ST_CAPTURE);
    status_nxt[STAT_ARMED]                         = (state == ST_ARMED);
    status_nxt[STAT_TRIG_MODE]                     = trig_mode;
    status_nxt[STAT_ARM_CNT_MSB:STAT_ARM_CNT_LSB]  = arm_cnt;
    status_nxt[STAT_COUNT_MSB:0]                   = 17'(count);
  end

  // Datapath and output registers
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      count      <= '0;
      arm_cnt    <= '0;
      trig_mode  <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      status_out <= '0;
    end else begin
      count      <= count_nxt;
      arm_cnt    <= arm_cnt_nxt;
      trig_mode  <= trig_mode_nxt;
      bram_we    <= we_nxt;
      bram_addr  <= addr_nxt;
      bram_din   <= din_nxt;
      status_out <= status_nxt;
    end
  end

endmodule
